tlul_err_gate: RTL and testbench
================================

TLUL_ERR_GATE -- requirements
Module: tlul_err_gate

Interface
REQ-001 SHALL have parameter ErrCntW, default 16, meaning width of the saturating error counter.
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tl_h_i  input  tl_h2d_t  host-side A-channel request and D-channel d_ready.
REQ-005 SHALL have port tl_h_o  output  tl_d2h_t  host-side a_ready and D-channel response.
REQ-006 SHALL have port tl_d_o  output  tl_h2d_t  device-side forwarded request and d_ready.
REQ-007 SHALL have port tl_d_i  input  tl_d2h_t  device-side a_ready and D-channel response.
REQ-008 SHALL have port err_cnt_clr_i  input  1  synchronous clear of err_cnt_o.
REQ-009 SHALL have port err_cnt_o  output  ErrCntW  count of rejected requests, saturating.
REQ-010 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL treat the bus as 64-bit data, 8-bit mask; lane index = a_address[2:0].
REQ-012 SHALL deem a request legal only if: opcode is Get, PutFullData or PutPartialData; a_size <= 3; address aligned to 2^a_size; a_mask has no bits outside the 2^a_size lanes starting at the aligned lane; for PutFullData all those lanes set.
REQ-013 SHALL use FSM states IDLE, FWD_WAIT, ERR_RESP; at most one request outstanding.
REQ-014 IDLE, legal request: tl_d_o.a_valid = tl_h_i.a_valid, all A fields passed unmodified, tl_h_o.a_ready = tl_d_i.a_ready; on a_valid & a_ready go to FWD_WAIT.
REQ-015 IDLE, illegal request: tl_d_o.a_valid = 0, tl_h_o.a_ready = 1; on a_valid capture a_opcode, a_source, a_size, increment counter, go to ERR_RESP.
REQ-016 FWD_WAIT: tl_h_o.a_ready = 0, tl_d_o.a_valid = 0; D channel passes through both ways (d_valid, d_ready, all d_* fields); on d_valid & d_ready go to IDLE.
REQ-017 ERR_RESP: tl_h_o.d_valid = 1, d_error = 1, d_opcode = AccessAckData if captured opcode is Get else AccessAck, d_source/d_size = captured values, d_data = all ones, d_sink = 0, d_param = 0; tl_d_o.d_ready = 0; on tl_h_i.d_ready go to IDLE.
REQ-018 IDLE: tl_h_o.d_valid = 0, tl_d_o.d_ready = 0; any device d_valid is ignored.
REQ-019 d_valid in ERR_RESP SHALL hold, with fields stable, until accepted.
REQ-020 Return to IDLE SHALL take effect next cycle; a new request SHALL NOT be accepted in the same cycle as the D handshake (max one transaction per 2 cycles).
REQ-021 Counter SHALL increment by 1 per rejected request, saturate at 2^ErrCntW-1 and hold.
REQ-022 err_cnt_clr_i coincident with an increment: clear wins, counter = 0.
REQ-023 Legality check SHALL be combinational from A fields; a_ready SHALL NOT depend on tl_h_i.a_valid.

Reset
REQ-024 On rst_ni low, immediately: state = IDLE, err_cnt_o = 0, busy_o = 0, captured fields = 0, tl_h_o.d_valid = 0, tl_d_o.a_valid = 0.
REQ-025 Reset during FWD_WAIT or ERR_RESP SHALL abandon the transaction; no response issued after release.
REQ-026 First request SHALL be accepted on the first clock edge after rst_ni deasserts.

Verification
REQ-027 Get, size 3, addr 0x1000, mask 0xFF, device ready -> forwarded unchanged, device AccessAckData data 0x1122334455667788 passed to host, busy_o high 1+ cycles then low.
REQ-028 PutFullData, size 2, addr 0x1004, mask 0x0F -> rejected (mask outside lanes 4-7), no device a_valid, AccessAck d_error=1 source echoed, err_cnt_o = 1.
REQ-029 PutPartialData, size 1, addr 0x1003 -> rejected (misaligned); Get with a_size 4 -> rejected AccessAckData d_data 0xFFFFFFFFFFFFFFFF; opcode 3 -> rejected; err_cnt_o = 3.
REQ-030 ERR_RESP with host d_ready low 5 cycles -> d_valid and fields stable all 5 cycles, IDLE one cycle after d_ready.
REQ-031 ErrCntW=2, 4 rejects -> err_cnt_o 1,2,3,3; clr with reject same cycle -> 0.
REQ-032 rst_ni low mid FWD_WAIT -> outputs at reset values asynchronously, later device d_valid ignored, new request accepted after release.

Source files
------------

// File: rtl/tlul_err_gate.sv
// TL-UL request legality gate: forwards well-formed requests to the device and answers
// malformed ones locally with an error response, counting each rejection.

package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [7:0]  a_mask;
        logic [63:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [2:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [63:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

endpackage

module tlul_err_gate
    import tlul_pkg::*;
#(
    parameter int unsigned ErrCntW = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tl_h2d_t            tl_h_i,
    output tl_d2h_t            tl_h_o,
    output tl_h2d_t            tl_d_o,
    input  tl_d2h_t            tl_d_i,
    input  logic               err_cnt_clr_i,
    output logic [ErrCntW-1:0] err_cnt_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StFwdWait,
        StErrResp
    } state_e;

    state_e state_q, state_d;

    logic [2:0]         cap_opcode_q, cap_opcode_d;
    logic [7:0]         cap_source_q, cap_source_d;
    logic [2:0]         cap_size_q, cap_size_d;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
    logic               err_inc;

    logic [7:0] lane_mask;
    logic [2:0] align_bits;
    logic       op_ok, size_ok, align_ok, mask_ok, full_ok, legal;

    // Byte lanes covered by the access, starting at the aligned lane.
    always_comb begin
        lane_mask  = 8'h00;
        align_bits = 3'b111;
        case (tl_h_i.a_size)
            3'd0: begin
                lane_mask  = 8'h01 << tl_h_i.a_address[2:0];
                align_bits = 3'b000;
            end
            3'd1: begin
                lane_mask  = 8'h03 << tl_h_i.a_address[2:0];
                align_bits = 3'b001;
            end
            3'd2: begin
                lane_mask  = 8'h0f << tl_h_i.a_address[2:0];
                align_bits = 3'b011;
            end
            3'd3: begin
                lane_mask  = 8'hff;
                align_bits = 3'b111;
            end
            default: begin
                lane_mask  = 8'h00;
                align_bits = 3'b111;
            end
        endcase
    end

    assign op_ok    = (tl_h_i.a_opcode == Get) || (tl_h_i.a_opcode == PutFullData) ||
                      (tl_h_i.a_opcode == PutPartialData);
    assign size_ok  = (tl_h_i.a_size <= 3'd3);
    assign align_ok = ((tl_h_i.a_address[2:0] & align_bits) == 3'b000);
    assign mask_ok  = ((tl_h_i.a_mask & ~lane_mask) == 8'h00);
    assign full_ok  = (tl_h_i.a_opcode != PutFullData) || (tl_h_i.a_mask == lane_mask);
    assign legal    = op_ok && size_ok && align_ok && mask_ok && full_ok;

    always_comb begin
        state_d      = state_q;
        cap_opcode_d = cap_opcode_q;
        cap_source_d = cap_source_q;
        cap_size_d   = cap_size_q;
        err_inc      = 1'b0;

        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = 1'b0;
        tl_d_o.d_ready = 1'b0;

        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = 1'b0;
        tl_h_o.d_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (legal) begin
                    tl_d_o.a_valid = tl_h_i.a_valid;
                    tl_h_o.a_ready = tl_d_i.a_ready;
                    if (tl_h_i.a_valid && tl_d_i.a_ready) begin
                        state_d = StFwdWait;
                    end
                end else begin
                    // Illegal requests are always sunk so the host never stalls on them.
                    tl_h_o.a_ready = 1'b1;
                    if (tl_h_i.a_valid) begin
                        cap_opcode_d = tl_h_i.a_opcode;
                        cap_source_d = tl_h_i.a_source;
                        cap_size_d   = tl_h_i.a_size;
                        err_inc      = 1'b1;
                        state_d      = StErrResp;
                    end
                end
            end
            StFwdWait: begin
                tl_h_o.d_valid = tl_d_i.d_valid;
                tl_d_o.d_ready = tl_h_i.d_ready;
                if (tl_d_i.d_valid && tl_h_i.d_ready) begin
                    state_d = StIdle;
                end
            end
            StErrResp: begin
                tl_h_o.d_valid  = 1'b1;
                tl_h_o.d_error  = 1'b1;
                tl_h_o.d_opcode = (cap_opcode_q == Get) ? AccessAckData : AccessAck;
                tl_h_o.d_param  = 3'h0;
                tl_h_o.d_size   = cap_size_q;
                tl_h_o.d_source = cap_source_q;
                tl_h_o.d_sink   = 1'b0;
                tl_h_o.d_data   = '1;
                if (tl_h_i.d_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Clear takes priority over a coincident increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr_i) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ErrCntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cap_opcode_q <= 3'h0;
            cap_source_q <= 8'h00;
            cap_size_q   <= 3'h0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cap_opcode_q <= cap_opcode_d;
            cap_source_q <= cap_source_d;
            cap_size_q   <= cap_size_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_tlul_err_gate.sv
// Randomized self-checking bench for tlul_err_gate against a rule-level legality and
// transaction model; a second instance with a 2-bit counter covers saturation.

module tb_tlul_err_gate;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tl_h2d_t     h_i, d_o, d_o2;
    tl_d2h_t     d_i, h_o, h_o2;
    logic        clr, clr2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        busy, busy2;

    int vectors = 0;
    int miscompares = 0;
    int model_cnt = 0;
    int model_cnt2 = 0;

    tlul_err_gate dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tl_h_i        (h_i),
        .tl_h_o        (h_o),
        .tl_d_o        (d_o),
        .tl_d_i        (d_i),
        .err_cnt_clr_i (clr),
        .err_cnt_o     (cnt),
        .busy_o        (busy)
    );

    tlul_err_gate #(.ErrCntW(2)) dut2 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tl_h_i        (h_i),
        .tl_h_o        (h_o2),
        .tl_d_o        (d_o2),
        .tl_d_i        (d_i),
        .err_cnt_clr_i (clr2),
        .err_cnt_o     (cnt2),
        .busy_o        (busy2)
    );

    function automatic bit legal_model(input logic [2:0] op, input logic [2:0] size,
                                       input logic [31:0] addr, input logic [7:0] mask);
        int nbytes;
        int low;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b0;
        if (size > 3'd3) return 1'b0;
        nbytes = 1 << size;
        low = int'(addr[2:0]);
        if ((low % nbytes) != 0) return 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit in_win;
            in_win = (i >= low) && (i < low + nbytes);
            if (mask[i] && !in_win) return 1'b0;
            if (op == 3'd0 && in_win && !mask[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic count_reject();
        if (model_cnt < 65535) model_cnt++;
        if (model_cnt2 < 3) model_cnt2++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        h_i = '0;
        d_i = '0;
        d_i.a_ready = 1'b1;
        clr = 1'b0;
        clr2 = 1'b0;
        model_cnt = 0;
        model_cnt2 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One complete transaction; host keeps a_valid high throughout to prove no second accept.
    task automatic do_txn(input logic [2:0] op, input logic [2:0] size, input logic [31:0] addr,
                          input logic [7:0] mask, input logic [7:0] src,
                          input logic [63:0] dev_data, input int dly);
        bit      legal;
        tl_h2d_t exp_a;
        tl_d2h_t exp_d;
        legal = legal_model(op, size, addr, mask);
        h_i.a_valid = 1'b1;
        h_i.a_opcode = op;
        h_i.a_param = 3'($urandom);
        h_i.a_size = size;
        h_i.a_address = addr;
        h_i.a_mask = mask;
        h_i.a_source = src;
        h_i.a_data = {$urandom, $urandom};
        h_i.d_ready = 1'b0;
        d_i = '0;
        d_i.a_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (legal) begin
            exp_a = h_i;
            exp_a.d_ready = 1'b0;
            if (d_o !== exp_a || h_o.a_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fwd_req: got %h/%b expected %h/1", d_o, h_o.a_ready, exp_a);
            end
        end else begin
            if ({d_o.a_valid, h_o.a_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL reject_req: got a_valid/a_ready %b%b expected 01",
                         d_o.a_valid, h_o.a_ready);
            end
        end
        @(posedge clk);
        #1;
        if (!legal) count_reject();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept: got %b expected 1", busy);
        end
        if (legal) begin
            for (int i = 0; i < dly; i++) begin
                h_i.d_ready = 1'b1;
                @(negedge clk);
                vectors++;
                if ({h_o.d_valid, h_o.a_ready, d_o.a_valid, d_o.d_ready} !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL fwd_wait: got %b expected 0001",
                             {h_o.d_valid, h_o.a_ready, d_o.a_valid, d_o.d_ready});
                end
                @(posedge clk);
                #1;
            end
            d_i.d_valid = 1'b1;
            d_i.d_opcode = (op == Get) ? AccessAckData : AccessAck;
            d_i.d_param = 3'($urandom);
            d_i.d_size = size;
            d_i.d_source = src;
            d_i.d_sink = 1'($urandom);
            d_i.d_data = dev_data;
            d_i.d_error = 1'($urandom);
            h_i.d_ready = 1'b1;
            @(negedge clk);
            exp_d = d_i;
            exp_d.a_ready = 1'b0;
            vectors++;
            if (h_o !== exp_d || d_o.d_ready !== 1'b1 || d_o.a_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fwd_resp: got %h/%b/%b expected %h/1/0",
                         h_o, d_o.d_ready, d_o.a_valid, exp_d);
            end
        end else begin
            exp_d = '0;
            exp_d.d_valid = 1'b1;
            exp_d.d_error = 1'b1;
            exp_d.d_opcode = (op == Get) ? AccessAckData : AccessAck;
            exp_d.d_size = size;
            exp_d.d_source = src;
            exp_d.d_data = 64'hffff_ffff_ffff_ffff;
            // Device noise on the D channel must not leak through an error response.
            d_i.d_valid = 1'b1;
            d_i.d_data = {$urandom, $urandom};
            d_i.d_sink = 1'b1;
            for (int i = 0; i <= dly; i++) begin
                h_i.d_ready = (i == dly);
                @(negedge clk);
                vectors++;
                if (h_o !== exp_d || d_o.d_ready !== 1'b0 || d_o.a_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL err_resp cycle %0d: got %h/%b/%b expected %h/0/0",
                             i, h_o, d_o.d_ready, d_o.a_valid, exp_d);
                end
                if (i != dly) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(posedge clk);
        #1;
        h_i.a_valid = 1'b0;
        h_i.d_ready = 1'b0;
        d_i.d_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || cnt !== 16'(model_cnt) || cnt2 !== 2'(model_cnt2)) begin
            miscompares++;
            $display("FAIL txn_end: got busy %b cnt %0d cnt2 %0d expected 0 %0d %0d",
                     busy, cnt, cnt2, model_cnt, model_cnt2);
        end
    endtask

    task automatic test_reset();
        h_i = '0;
        d_i = '0;
        d_i.d_valid = 1'b1;
        clr = 1'b0;
        clr2 = 1'b0;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({busy, h_o.d_valid, d_o.a_valid} !== 3'b000 || cnt !== 16'd0 || cnt2 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %b cnt %0d expected 000 cnt 0",
                     {busy, h_o.d_valid, d_o.a_valid}, cnt);
        end
        apply_reset();
    endtask

    task automatic test_legal_get();
        do_txn(Get, 3'd3, 32'h1000, 8'hff, 8'h5a, 64'h1122_3344_5566_7788, 2);
        do_txn(PutPartialData, 3'd1, 32'h1006, 8'h40, 8'h11, 64'h0, 0);
        do_txn(PutFullData, 3'd2, 32'h1004, 8'hf0, 8'h12, 64'h0, 1);
    endtask

    task automatic test_rejects();
        do_txn(PutFullData, 3'd2, 32'h1004, 8'h0f, 8'h21, 64'h0, 0);
        do_txn(PutPartialData, 3'd1, 32'h1003, 8'h08, 8'h22, 64'h0, 0);
        do_txn(Get, 3'd4, 32'h1000, 8'hff, 8'h23, 64'h0, 1);
        do_txn(3'd3, 3'd0, 32'h1000, 8'h01, 8'h24, 64'h0, 0);
    endtask

    task automatic test_backpressure();
        do_txn(PutFullData, 3'd2, 32'h1004, 8'h0f, 8'h77, 64'h0, 5);
        do_txn(Get, 3'd3, 32'h2000, 8'hff, 8'h78, {$urandom, $urandom}, 5);
    endtask

    task automatic test_sat_clear();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn(3'd2, 3'd0, 32'h3000, 8'h01, 8'(i), 64'h0, 0);
        end
        h_i.a_valid = 1'b1;
        h_i.a_opcode = 3'd5;
        h_i.a_size = 3'd0;
        h_i.a_mask = 8'h01;
        clr2 = 1'b1;
        @(posedge clk);
        #1;
        clr2 = 1'b0;
        h_i.a_valid = 1'b0;
        model_cnt2 = 0;
        if (model_cnt < 65535) model_cnt++;
        vectors++;
        if (cnt2 !== 2'd0 || cnt !== 16'(model_cnt)) begin
            miscompares++;
            $display("FAIL clr_vs_inc: got cnt2 %0d cnt %0d expected 0 %0d",
                     cnt2, cnt, model_cnt);
        end
        h_i.d_ready = 1'b1;
        @(posedge clk);
        #1;
        h_i.d_ready = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_cnt = 0;
        vectors++;
        if (busy !== 1'b0 || cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL clr_idle: got busy %b cnt %0d expected 0 0", busy, cnt);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op, size;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd2, 3'd3};
        int          w;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(5, 0)];
            size = 3'($urandom_range(4, 0));
            addr = 32'h4000 | 32'($urandom_range(7, 0));
            if (($urandom % 4) != 0 && size <= 3'd3) begin
                if (($urandom % 2) != 0) addr = addr & ~32'((1 << size) - 1);
                w = (1 << (1 << size)) - 1;
                mask = 8'(w << addr[2:0]);
                if (op != 3'd0 && ($urandom % 2) != 0) mask = mask & 8'($urandom);
            end else begin
                mask = 8'($urandom);
            end
            do_txn(op, size, addr, mask, 8'($urandom), {$urandom, $urandom},
                   $urandom_range(2, 0));
        end
    endtask

    task automatic test_reset_mid();
        h_i = '0;
        h_i.a_valid = 1'b1;
        h_i.a_opcode = Get;
        h_i.a_size = 3'd3;
        h_i.a_address = 32'h5000;
        h_i.a_mask = 8'hff;
        d_i = '0;
        d_i.a_ready = 1'b1;
        @(posedge clk);
        #1;
        h_i.a_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_accept: got busy %b expected 1", busy);
        end
        #2;
        rst_n = 1'b0;
        d_i.d_valid = 1'b1;
        h_i.d_ready = 1'b1;
        #1;
        model_cnt = 0;
        model_cnt2 = 0;
        vectors++;
        if ({busy, h_o.d_valid, d_o.a_valid, d_o.d_ready} !== 4'b0000 || cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %b cnt %0d expected 0000 cnt 0",
                     {busy, h_o.d_valid, d_o.a_valid, d_o.d_ready}, cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, h_o.d_valid, d_o.d_ready} !== 3'b000) begin
                miscompares++;
                $display("FAIL stale_resp: got %b expected 000", {busy, h_o.d_valid, d_o.d_ready});
            end
        end
        @(posedge clk);
        #1;
        d_i.d_valid = 1'b0;
        h_i.d_ready = 1'b0;
        do_txn(Get, 3'd2, 32'h5004, 8'hf0, 8'h99, {$urandom, $urandom}, 1);
    endtask

    initial begin
        test_reset();
        test_legal_get();
        test_rejects();
        test_backpressure();
        test_sat_clear();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
